// File: rtl/fsm_counter_pkg.sv
// Shared definitions for the run/idle/done counter controller:
// state encodings and the latched mode constants.
package fsm_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic MODE_ONE_SHOT = 1'b0;
    localparam logic MODE_RELOAD   = 1'b1;

endpackage

// File: rtl/fsm_counter_core.sv
// Up-counter with synchronous clear and increment enable, plus a compare
// against the latched last value (N-1) used by the controller FSM.
module fsm_counter_core
    import fsm_counter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] last_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over increment, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == last_i);

endmodule

// File: rtl/fsm_counter_ctrl.sv
// Run/idle/done counter controller with one-shot or auto-reload modes,
// pause/resume, abort and a saturating completed-period counter.
module fsm_counter_ctrl
    import fsm_counter_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int PRD_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_run,
    input  logic [CNT_W-1:0] i_num_cnt,
    input  logic             i_mode,
    input  logic             i_pause,
    input  logic             i_abort,
    output logic             o_idle,
    output logic             o_running,
    output logic             o_paused,
    output logic             o_done,
    output logic             o_period,
    output logic [CNT_W-1:0] o_cnt,
    output logic [PRD_W-1:0] o_prd_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PRD_W-1:0] PRD_ONE = PRD_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic             mode_q, mode_d;
    logic             period_q, period_d;
    logic [PRD_W-1:0] prd_q, prd_d;

    logic             clr_s;
    logic             inc_s;
    logic             tc_s;
    logic [CNT_W-1:0] cnt_s;

    fsm_counter_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (clr_s),
        .inc_i   (inc_s),
        .last_i  (last_q),
        .cnt_o   (cnt_s),
        .tc_o    (tc_s)
    );

    // Next-state and datapath control; abort > pause > terminal > increment.
    // The cycle leaving PAUSE counts like a RUN cycle so each pause cycle
    // costs exactly one cycle of run time.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        mode_d   = mode_q;
        period_d = 1'b0;
        prd_d    = prd_q;
        clr_s    = 1'b0;
        inc_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_run && (i_num_cnt != '0)) begin
                    state_d = ST_RUN;
                    last_d  = i_num_cnt - CNT_ONE;
                    mode_d  = i_mode;
                    prd_d   = '0;
                    clr_s   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN, ST_PAUSE: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                    clr_s   = 1'b1;
                end else if (i_pause) begin
                    state_d = ST_PAUSE;
                end else if (tc_s) begin
                    if (mode_q == MODE_RELOAD) begin
                        state_d  = ST_RUN;
                        clr_s    = 1'b1;
                        period_d = 1'b1;
                        prd_d    = (prd_q == '1) ? prd_q : (prd_q + PRD_ONE);
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_RUN;
                    inc_s   = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                clr_s   = 1'b1;
            end
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            last_q   <= '0;
            mode_q   <= MODE_ONE_SHOT;
            period_q <= 1'b0;
            prd_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            prd_q    <= prd_d;
        end
    end

    assign o_idle    = (state_q == ST_IDLE);
    assign o_running = (state_q == ST_RUN);
    assign o_paused  = (state_q == ST_PAUSE);
    assign o_done    = (state_q == ST_DONE);
    assign o_period  = period_q;
    assign o_cnt     = cnt_s;
    assign o_prd_cnt = prd_q;

endmodule

// File: tb/tb_fsm_counter_ctrl.sv
// Directed, self-checking bench for fsm_counter_ctrl: a vector table for
// single-cycle behaviour plus hand-written multi-cycle sequences.
module tb_fsm_counter_ctrl;

    logic        clk;
    logic        reset_n;
    logic        run, mode, pause, abort;
    logic [15:0] num;
    logic        idle, running, paused, done, period;
    logic [15:0] cnt;
    logic [7:0]  prd;

    logic        run2, mode2, pause2, abort2;
    logic [15:0] num2;
    logic        idle2, running2, paused2, done2, period2;
    logic [15:0] cnt2;
    logic [1:0]  prd2;

    int checks = 0;
    int errors = 0;

    fsm_counter_ctrl #(.CNT_W(16), .PRD_W(8)) u_dut (
        .clk(clk), .reset_n(reset_n), .i_run(run), .i_num_cnt(num),
        .i_mode(mode), .i_pause(pause), .i_abort(abort),
        .o_idle(idle), .o_running(running), .o_paused(paused), .o_done(done),
        .o_period(period), .o_cnt(cnt), .o_prd_cnt(prd)
    );

    fsm_counter_ctrl #(.CNT_W(16), .PRD_W(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .i_run(run2), .i_num_cnt(num2),
        .i_mode(mode2), .i_pause(pause2), .i_abort(abort2),
        .o_idle(idle2), .o_running(running2), .o_paused(paused2), .o_done(done2),
        .o_period(period2), .o_cnt(cnt2), .o_prd_cnt(prd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        run;
        logic [15:0] num;
        logic        mode;
        logic        pause;
        logic        abort;
        logic [3:0]  st;   // {idle, running, paused, done}
        logic        per;
        logic [15:0] cnt;
        logic [7:0]  prd;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mkv(logic r, logic [15:0] n, logic m, logic p, logic a,
                                 logic [3:0] st, logic per, logic [15:0] c, logic [7:0] pr);
        vec_t v;
        v.run = r; v.num = n; v.mode = m; v.pause = p; v.abort = a;
        v.st = st; v.per = per; v.cnt = c; v.prd = pr;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] st, input logic per,
                           input int c, input int pr);
        chk({tag, ".idle"},    int'(idle),    int'(st[3]));
        chk({tag, ".running"}, int'(running), int'(st[2]));
        chk({tag, ".paused"},  int'(paused),  int'(st[1]));
        chk({tag, ".done"},    int'(done),    int'(st[0]));
        chk({tag, ".period"},  int'(period),  int'(per));
        chk({tag, ".cnt"},     int'(cnt),     c);
        chk({tag, ".prd"},     int'(prd),     pr);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [3:0] S_IDLE = 4'b1000;
    localparam logic [3:0] S_RUN  = 4'b0100;
    localparam logic [3:0] S_PAU  = 4'b0010;
    localparam logic [3:0] S_DONE = 4'b0001;

    initial begin
        run = 1'b0; num = 16'd0; mode = 1'b0; pause = 1'b0; abort = 1'b0;
        run2 = 1'b0; num2 = 16'd0; mode2 = 1'b0; pause2 = 1'b0; abort2 = 1'b0;
        reset_n = 1'b0;

        vecs[0]  = mkv(1'b1, 16'd3, 1'b0, 1'b0, 1'b0, S_RUN,  1'b0, 16'd0, 8'd0);
        vecs[1]  = mkv(1'b0, 16'd7, 1'b1, 1'b0, 1'b0, S_RUN,  1'b0, 16'd1, 8'd0);
        vecs[2]  = mkv(1'b0, 16'd7, 1'b1, 1'b1, 1'b0, S_PAU,  1'b0, 16'd1, 8'd0);
        vecs[3]  = mkv(1'b1, 16'd7, 1'b1, 1'b0, 1'b0, S_RUN,  1'b0, 16'd2, 8'd0);
        vecs[4]  = mkv(1'b0, 16'd7, 1'b1, 1'b0, 1'b0, S_DONE, 1'b0, 16'd2, 8'd0);
        vecs[5]  = mkv(1'b0, 16'd7, 1'b1, 1'b0, 1'b1, S_IDLE, 1'b0, 16'd2, 8'd0);
        vecs[6]  = mkv(1'b1, 16'd0, 1'b1, 1'b0, 1'b0, S_IDLE, 1'b0, 16'd2, 8'd0);
        vecs[7]  = mkv(1'b1, 16'd2, 1'b1, 1'b0, 1'b0, S_RUN,  1'b0, 16'd0, 8'd0);
        vecs[8]  = mkv(1'b0, 16'd9, 1'b0, 1'b0, 1'b0, S_RUN,  1'b0, 16'd1, 8'd0);
        vecs[9]  = mkv(1'b0, 16'd9, 1'b0, 1'b0, 1'b0, S_RUN,  1'b1, 16'd0, 8'd1);
        vecs[10] = mkv(1'b0, 16'd9, 1'b0, 1'b1, 1'b0, S_PAU,  1'b0, 16'd0, 8'd1);
        vecs[11] = mkv(1'b0, 16'd9, 1'b0, 1'b1, 1'b1, S_IDLE, 1'b0, 16'd0, 8'd1);
        vecs[12] = mkv(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b0, 16'd0, 8'd1);

        #12;
        chk_all("reset", S_IDLE, 1'b0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 13; i++) begin
            run = vecs[i].run; num = vecs[i].num; mode = vecs[i].mode;
            pause = vecs[i].pause; abort = vecs[i].abort;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].per,
                    int'(vecs[i].cnt), int'(vecs[i].prd));
        end

        // One-shot N=100, no pause.
        run = 1'b1; num = 16'd100; mode = 1'b0;
        step();
        run = 1'b0;
        for (int i = 0; i < 100; i++) begin
            chk_all($sformatf("os100_c%0d", i), S_RUN, 1'b0, i, 0);
            step();
        end
        chk_all("os100_done", S_DONE, 1'b0, 99, 0);
        step();
        chk_all("os100_idle", S_IDLE, 1'b0, 99, 0);

        // One-shot N=10 with a 5-cycle pause at count 4; done at t0+16.
        run = 1'b1; num = 16'd10; mode = 1'b0;
        step();
        run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("p10_cnt", int'(cnt), i);
            step();
        end
        chk("p10_cnt4", int'(cnt), 4);
        pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_all($sformatf("p10_pause%0d", k), S_PAU, 1'b0, 4, 0);
        end
        pause = 1'b0;
        for (int i = 5; i < 10; i++) begin
            step();
            chk_all($sformatf("p10_c%0d", i), S_RUN, 1'b0, i, 0);
        end
        step();
        chk_all("p10_done", S_DONE, 1'b0, 9, 0);
        step();
        chk("p10_idle", int'(idle), 1);

        // Auto-reload N=5 for 23 cycles, then abort.
        run = 1'b1; num = 16'd5; mode = 1'b1;
        step();
        run = 1'b0;
        for (int j = 1; j <= 23; j++) begin
            chk_all($sformatf("ar5_j%0d", j), S_RUN,
                    ((j > 1) && ((j - 1) % 5 == 0)) ? 1'b1 : 1'b0,
                    (j - 1) % 5, (j - 1) / 5);
            if (j < 23) step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_all("ar5_abort", S_IDLE, 1'b0, 0, 4);
        step();
        chk_all("ar5_after", S_IDLE, 1'b0, 0, 4);

        // PRD_W=2, auto-reload N=1: period every cycle, count saturates at 3.
        run2 = 1'b1; num2 = 16'd1; mode2 = 1'b1;
        step();
        run2 = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            chk($sformatf("sat_run_j%0d", j), int'(running2), 1);
            chk($sformatf("sat_cnt_j%0d", j), int'(cnt2), 0);
            chk($sformatf("sat_per_j%0d", j), int'(period2), (j >= 2) ? 1 : 0);
            chk($sformatf("sat_prd_j%0d", j), int'(prd2), (j - 1 > 3) ? 3 : j - 1);
            step();
        end
        abort2 = 1'b1;
        step();
        abort2 = 1'b0;
        chk("sat_idle", int'(idle2), 1);
        chk("sat_prd_hold", int'(prd2), 3);

        // Asynchronous reset at count 50 of N=100.
        run = 1'b1; num = 16'd100; mode = 1'b0;
        step();
        run = 1'b0;
        for (int i = 0; i < 50; i++) step();
        chk("rst_pre_cnt", int'(cnt), 50);
        reset_n = 1'b0;
        #1;
        chk_all("rst_async", S_IDLE, 1'b0, 0, 0);
        step();
        step();
        chk_all("rst_held", S_IDLE, 1'b0, 0, 0);
        reset_n = 1'b1;
        step();
        chk_all("rst_release", S_IDLE, 1'b0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm_counter_ctrl.md
# fsm_counter_ctrl

Parametrised run/idle/done counter controller, the next generation of our single-shot FSM counter. Adds configurable count width, auto-reload (periodic) mode, pause/resume, abort, and visible count/period outputs. Sits between a control register block and any datapath that needs a timed "running" window or periodic tick.

## Interface
- `CNT_W`, 16: width of the target count and of the running count (min 2).
- `PRD_W`, 8: width of the completed-period counter.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `i_run` in 1: start request, sampled in IDLE only.
- `i_num_cnt` in CNT_W: target count N, latched on accepted start.
- `i_mode` in 1: 0 = one-shot, 1 = auto-reload; latched on accepted start.
- `i_pause` in 1: level; freezes counting while high in RUN.
- `i_abort` in 1: level; returns to IDLE from RUN/PAUSE without done.
- `o_idle`, `o_running`, `o_paused`, `o_done` out 1 each: state decodes, one-hot across the four states.
- `o_period` out 1: one-cycle pulse on each auto-reload wrap.
- `o_cnt` out CNT_W: current count.
- `o_prd_cnt` out PRD_W: completed periods since last start, saturating.

## Operation
- States: IDLE, RUN, PAUSE, DONE; 2-bit registered state, Moore outputs decoded from state register.
- IDLE: `i_run`=1 and `i_num_cnt`!=0 -> latch N and mode, clear `o_cnt` and `o_prd_cnt`, go RUN. `i_run` with `i_num_cnt`=0 is ignored (stay IDLE, nothing latched).
- RUN: `o_cnt` increments by 1 per cycle. Terminal when `o_cnt`==N-1:
  - one-shot -> DONE, `o_cnt` holds N-1.
  - auto-reload -> `o_cnt` wraps to 0, `o_period` pulses, `o_prd_cnt` +1 (saturates at 2^PRD_W-1), stay RUN.
- RUN with `i_pause`=1 -> PAUSE; no increment and no terminal action in that cycle.
- PAUSE: `o_cnt` frozen; `i_pause`=0 -> RUN, counting resumes next cycle from the held value.
- `i_abort`=1 in RUN or PAUSE -> IDLE, `o_cnt` cleared, no `o_done`, no `o_period`. Priority: abort > pause > terminal > increment.
- DONE: lasts exactly one cycle (`o_done` is a 1-cycle pulse), then IDLE unconditionally; `i_abort` ignored in DONE.
- `i_run` outside IDLE is ignored; changes to `i_num_cnt`/`i_mode` after start have no effect.
- `o_prd_cnt` holds its value in IDLE and DONE until the next accepted start.

## Timing
- Reset: state IDLE; `o_idle`=1; `o_running`, `o_paused`, `o_done`, `o_period`=0; `o_cnt`=0; `o_prd_cnt`=0.
- Start accepted at edge t0 -> `o_running`=1 from t0+1, `o_cnt`=0 at t0+1.
- One-shot, no pause: `o_cnt` = 0..N-1 over N RUN cycles; `o_done`=1 in cycle t0+N+1; `o_idle`=1 from t0+N+2.
- Each pause cycle extends the run by exactly one cycle.
- Auto-reload: `o_period` asserts in the cycle after `o_cnt`==N-1, coincident with `o_cnt`=0; period = N cycles.
- N=1: one-shot gives one RUN cycle then DONE; auto-reload pulses `o_period` every cycle.
- `reset_n` low mid-run: immediate return to reset values, asynchronously.

## Structure
- Shared package/header `fsm_counter_pkg`: state encodings (IDLE=0, RUN=1, PAUSE=2, DONE=3), mode constants (ONE_SHOT=0, RELOAD=1).
- One sub-module, `fsm_counter_core`: CNT_W up-counter with clear/enable and terminal-compare output; FSM and period counter stay in top.

## Test plan
- Reset then one-shot N=100, no pause -> `o_running` 100 cycles, `o_cnt` ends at 99, `o_done` single pulse at t0+101, `o_idle` at t0+102.
- One-shot N=10, `i_pause` high for 5 cycles at `o_cnt`=4 -> `o_paused` 5 cycles, `o_cnt` held at 4, `o_done` at t0+16.
- Auto-reload N=5 for 23 cycles then abort -> `o_period` every 5 cycles, `o_prd_cnt`=4, IDLE after abort, `o_cnt`=0, no `o_done`.
- `i_run` with `i_num_cnt`=0 -> stays IDLE; `i_run` pulsed during RUN -> ignored, count unaffected.
- PRD_W=2, auto-reload N=1 for 10 cycles -> `o_prd_cnt` saturates at 3.
- `reset_n` low at `o_cnt`=50 of N=100 -> all outputs return to reset values immediately; no `o_done`.
